// File: rtl/ahf_mem_arb_pkg.sv
// Shared types for the mRISC521 memory arbiter: requester ownership,
// arbitration state and the read-tag record carried alongside each read.
package ahf_mem_arb_pkg;

  localparam int DEF_AW = 8;
  localparam int DEF_DW = 16;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_e;

  typedef enum logic {
    DM_PRI   = 1'b0,
    IF_FORCE = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic   valid;
    owner_e owner;
  } rtag_t;

endpackage

// File: rtl/ahf_rtag_pipe.sv
// Delay line of read tags matching the memory read latency; the output stage
// tells the arbiter which requester owns the word on mem_rdata this cycle.
module ahf_rtag_pipe
  import ahf_mem_arb_pkg::*;
#(
  parameter int MEM_LAT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic in_vld,
  input  logic in_dm,
  output logic out_vld,
  output logic out_dm,
  output logic busy
);

  rtag_t tag_p [MEM_LAT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MEM_LAT; i++) tag_p[i] <= '0;
    end else begin
      tag_p[0] <= '{valid: in_vld, owner: (in_dm ? OWN_DM : OWN_IF)};
      for (int i = 1; i < MEM_LAT; i++) tag_p[i] <= tag_p[i-1];
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < MEM_LAT; i++) busy = busy | tag_p[i].valid;
  end

  assign out_vld = tag_p[MEM_LAT-1].valid;
  assign out_dm  = (tag_p[MEM_LAT-1].owner == OWN_DM);

endmodule

// File: rtl/ahf_mem_arb.sv
// Single-port memory arbiter between instruction fetch and data load/store:
// data has priority, a starvation counter forces fetch progress.
module ahf_mem_arb
  import ahf_mem_arb_pkg::*;
#(
  parameter int AW         = DEF_AW,
  parameter int DW         = DEF_DW,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 3
) (
  input  logic          CLOCK_50,
  input  logic          Reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_gnt,
  output logic          dm_rvalid,
  output logic [DW-1:0] dm_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v >= STARVE_LIM) ? STARVE_LIM : v + CW'(1);
  endfunction

  arb_state_e    state_q, state_d;
  logic [CW-1:0] starve_cnt;
  logic          grant_if, grant_dm;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] if_rdata_q, dm_rdata_q;
  logic          tag_vld, tag_dm;

  // Grants are suppressed while Reset is held so requesters see no handshake.
  always_comb begin
    grant_if = 1'b0;
    grant_dm = 1'b0;
    state_d  = state_q;
    if (!Reset) begin
      if (state_q == IF_FORCE) begin
        grant_if = if_req;
        grant_dm = dm_req & ~if_req;
      end else begin
        grant_dm = dm_req;
        grant_if = if_req & ~dm_req;
      end
    end
    case (state_q)
      DM_PRI:   if (starve_cnt == STARVE_LIM && !grant_if) state_d = IF_FORCE;
      IF_FORCE: if (grant_if) state_d = DM_PRI;
      default:  state_d = DM_PRI;
    endcase
  end

  assign if_gnt    = grant_if;
  assign dm_gnt    = grant_dm;
  assign mem_en    = grant_if | grant_dm;
  assign mem_we    = grant_dm & dm_we;
  assign mem_addr  = grant_dm ? dm_addr : (grant_if ? if_addr : addr_q);
  assign mem_wdata = grant_dm ? dm_wdata : wdata_q;

  always_ff @(posedge CLOCK_50 or posedge Reset) begin
    if (Reset) begin
      state_q    <= DM_PRI;
      starve_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (if_req && !grant_if) starve_cnt <= sat_inc(starve_cnt);
      else                     starve_cnt <= '0;
    end
  end

  // Hold registers keep the bus and the non-owner read data stable when idle.
  always_ff @(posedge CLOCK_50 or posedge Reset) begin
    if (Reset) begin
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      if (mem_en)    addr_q     <= mem_addr;
      if (grant_dm)  wdata_q    <= dm_wdata;
      if (if_rvalid) if_rdata_q <= mem_rdata;
      if (dm_rvalid) dm_rdata_q <= mem_rdata;
    end
  end

  ahf_rtag_pipe #(
    .MEM_LAT (MEM_LAT)
  ) u_rtag_pipe (
    .clk     (CLOCK_50),
    .rst     (Reset),
    .in_vld  (mem_en & ~mem_we),
    .in_dm   (grant_dm),
    .out_vld (tag_vld),
    .out_dm  (tag_dm),
    .busy    (busy)
  );

  // Read return stage: steer the memory word to the tag's owner.
  assign if_rvalid = tag_vld & ~tag_dm;
  assign dm_rvalid = tag_vld & tag_dm;
  assign if_rdata  = if_rvalid ? mem_rdata : if_rdata_q;
  assign dm_rdata  = dm_rvalid ? mem_rdata : dm_rdata_q;

endmodule

// File: tb/tb_ahf_mem_arb.sv
// Scoreboard bench for ahf_mem_arb: a behavioural arbitration/memory model
// predicts grants and read returns; a monitor checks every rvalid in order.
module tb_ahf_mem_arb;

  localparam int AW   = 8;
  localparam int DW   = 16;
  localparam int LAT  = 1;
  localparam int SMAX = 3;

  logic CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  logic          Reset;
  logic          if_req, if_gnt, if_rvalid;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          dm_req, dm_we, dm_gnt, dm_rvalid;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata, dm_rdata;
  logic          mem_en, mem_we, busy;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  ahf_mem_arb #(.AW(AW), .DW(DW), .MEM_LAT(LAT), .STARVE_MAX(SMAX)) u_dut (
    .CLOCK_50 (CLOCK_50), .Reset (Reset),
    .if_req (if_req), .if_addr (if_addr), .if_gnt (if_gnt),
    .if_rvalid (if_rvalid), .if_rdata (if_rdata),
    .dm_req (dm_req), .dm_we (dm_we), .dm_addr (dm_addr), .dm_wdata (dm_wdata),
    .dm_gnt (dm_gnt), .dm_rvalid (dm_rvalid), .dm_rdata (dm_rdata),
    .mem_en (mem_en), .mem_we (mem_we), .mem_addr (mem_addr),
    .mem_wdata (mem_wdata), .mem_rdata (mem_rdata), .busy (busy)
  );

  // Second instance with a 3-cycle memory for the reset-during-read scenario.
  logic          r3_rst, r3_if_req, r3_if_gnt, r3_if_rvalid;
  logic [AW-1:0] r3_if_addr;
  logic [DW-1:0] r3_if_rdata;
  logic          r3_dm_req, r3_dm_we, r3_dm_gnt, r3_dm_rvalid;
  logic [AW-1:0] r3_dm_addr;
  logic [DW-1:0] r3_dm_wdata, r3_dm_rdata;
  logic          r3_mem_en, r3_mem_we, r3_busy;
  logic [AW-1:0] r3_mem_addr;
  logic [DW-1:0] r3_mem_wdata, r3_mem_rdata;

  ahf_mem_arb #(.AW(AW), .DW(DW), .MEM_LAT(3), .STARVE_MAX(SMAX)) u_dut3 (
    .CLOCK_50 (CLOCK_50), .Reset (r3_rst),
    .if_req (r3_if_req), .if_addr (r3_if_addr), .if_gnt (r3_if_gnt),
    .if_rvalid (r3_if_rvalid), .if_rdata (r3_if_rdata),
    .dm_req (r3_dm_req), .dm_we (r3_dm_we), .dm_addr (r3_dm_addr), .dm_wdata (r3_dm_wdata),
    .dm_gnt (r3_dm_gnt), .dm_rvalid (r3_dm_rvalid), .dm_rdata (r3_dm_rdata),
    .mem_en (r3_mem_en), .mem_we (r3_mem_we), .mem_addr (r3_mem_addr),
    .mem_wdata (r3_mem_wdata), .mem_rdata (r3_mem_rdata), .busy (r3_busy)
  );

  function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
    return (a == 8'h05) ? 16'h1234 : {a, a ^ 8'h5A};
  endfunction

  // Behavioural synchronous memories (contents survive Reset).
  logic [DW-1:0] mem [256];
  logic [DW-1:0] rd_pipe [LAT];
  bit            mem_ready = 1'b0;
  always @(posedge CLOCK_50) begin
    if (!mem_ready) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_word(8'(i));
      mem_ready <= 1'b1;
    end else if (mem_en && mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
    rd_pipe[0] <= mem[mem_addr];
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_rdata = rd_pipe[LAT-1];

  logic [DW-1:0] rd3 [3];
  always @(posedge CLOCK_50) begin
    rd3[0] <= init_word(r3_mem_addr);
    rd3[1] <= rd3[0];
    rd3[2] <= rd3[1];
  end
  assign r3_mem_rdata = rd3[2];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    bit            dm;
    logic [DW-1:0] data;
  } exp_t;
  exp_t sb_q[$];

  // Reference model state
  bit            m_force;
  int            m_denied;
  logic [DW-1:0] ref_mem [256];
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  bit            obs_if, obs_dm, obs_we;
  logic [DW-1:0] obs_wdata;

  task automatic check_cycle();
    bit e_if, e_dm;
    e_if = if_req && (m_force || !dm_req);
    e_dm = dm_req && !e_if;
    chk("if_gnt", 32'(if_gnt), 32'(e_if));
    chk("dm_gnt", 32'(dm_gnt), 32'(e_dm));
    chk("mem_en", 32'(mem_en), 32'(e_if || e_dm));
    chk("mem_we", 32'(mem_we), 32'(e_dm && dm_we));
    if (e_if) begin
      chk("mem_addr_if", 32'(mem_addr), 32'(if_addr));
      m_addr = if_addr;
      sb_q.push_back('{dm: 1'b0, data: ref_mem[if_addr]});
    end else if (e_dm) begin
      chk("mem_addr_dm", 32'(mem_addr), 32'(dm_addr));
      m_addr = dm_addr;
      m_wdata = dm_wdata;
      if (dm_we) begin
        chk("mem_wdata", 32'(mem_wdata), 32'(dm_wdata));
        ref_mem[dm_addr] = dm_wdata;
      end else begin
        sb_q.push_back('{dm: 1'b1, data: ref_mem[dm_addr]});
      end
    end else begin
      chk("mem_addr_hold", 32'(mem_addr), 32'(m_addr));
      chk("mem_wdata_hold", 32'(mem_wdata), 32'(m_wdata));
    end
    if (m_force) m_force = !e_if;
    else         m_force = (m_denied == SMAX) && !e_if;
    if (if_req && !e_if) m_denied = (m_denied < SMAX) ? m_denied + 1 : SMAX;
    else                 m_denied = 0;
    obs_if    = if_gnt;
    obs_dm    = dm_gnt;
    obs_we    = mem_we;
    obs_wdata = mem_wdata;
  endtask

  // One arbitration cycle: check at negedge, then drop granted requests.
  task automatic tick();
    @(negedge CLOCK_50);
    check_cycle();
    @(posedge CLOCK_50);
    #1;
    if (obs_if) if_req = 1'b0;
    if (obs_dm) dm_req = 1'b0;
  endtask

  logic [DW-1:0] last_if = '0;
  logic [DW-1:0] last_dm = '0;
  exp_t          mon_e;

  always @(negedge CLOCK_50) begin
    if (!Reset && (if_rvalid || dm_rvalid)) begin
      if (if_rvalid && dm_rvalid) begin
        chk("rvalid_onehot", 32'({if_rvalid, dm_rvalid}), 32'b01);
      end else if (sb_q.size() == 0) begin
        chk("rvalid_unexpected", 32'({if_rvalid, dm_rvalid}), 32'b00);
      end else begin
        mon_e = sb_q.pop_front();
        chk("rvalid_owner", 32'(dm_rvalid), 32'(mon_e.dm));
        chk("rdata", 32'(dm_rvalid ? dm_rdata : if_rdata), 32'(mon_e.data));
        if (mon_e.dm) begin
          chk("if_rdata_hold", 32'(if_rdata), 32'(last_if));
          last_dm = mon_e.data;
        end else begin
          chk("dm_rdata_hold", 32'(dm_rdata), 32'(last_dm));
          last_if = mon_e.data;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  int if_at;
  bit dm_hist [7];
  int guard;

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(8'(i));
    m_force = 1'b0; m_denied = 0; m_addr = '0; m_wdata = '0;
    r3_rst = 1'b1; r3_if_req = 1'b0; r3_if_addr = '0; r3_dm_req = 1'b0;
    r3_dm_we = 1'b0; r3_dm_addr = '0; r3_dm_wdata = '0;
    Reset = 1'b1;
    if_req = 1'b1; if_addr = 8'h01;
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 8'h02; dm_wdata = 16'hAAAA;

    // Reset held with requests active
    repeat (40) begin
      @(negedge CLOCK_50);
      chk("reset_ctrl", {25'b0, if_gnt, dm_gnt, mem_en, mem_we, if_rvalid, dm_rvalid, busy}, 32'h0);
      chk("reset_bus", {8'b0, mem_addr, mem_wdata}, 32'h0);
    end
    @(posedge CLOCK_50);
    #1;
    Reset = 1'b0;
    if_req = 1'b0;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 8'h10;
    tick();
    chk("first_dm_gnt", 32'(obs_dm), 32'd1);

    // IF read of word 05
    if_req = 1'b1; if_addr = 8'h05;
    tick();
    chk("if_read_gnt", 32'(obs_if), 32'd1);
    chk("if_read_rvalid", 32'(if_rvalid), 32'd1);
    chk("if_read_rdata", 32'(if_rdata), 32'h1234);
    chk("if_read_dm_rvalid", 32'(dm_rvalid), 32'd0);
    chk("if_read_busy", 32'(busy), 32'd1);
    tick();
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_rvalid", 32'({if_rvalid, dm_rvalid}), 32'd0);

    // Simultaneous requests
    if_req = 1'b1; if_addr = 8'h07;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 8'h20;
    tick();
    chk("conflict_first", 32'({obs_if, obs_dm}), 32'b01);
    chk("conflict_dm_rvalid", 32'(dm_rvalid), 32'd1);
    tick();
    chk("conflict_second", 32'({obs_if, obs_dm}), 32'b10);
    chk("conflict_if_rvalid", 32'({if_rvalid, dm_rvalid}), 32'b10);

    // Write then read back
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 8'h30; dm_wdata = 16'hBEEF;
    tick();
    chk("write_gnt_we", 32'({obs_dm, obs_we}), 32'b11);
    chk("write_wdata", 32'(obs_wdata), 32'hBEEF);
    chk("write_no_rvalid", 32'({if_rvalid, dm_rvalid, busy}), 32'd0);
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 8'h30;
    tick();
    chk("readback_rvalid", 32'(dm_rvalid), 32'd1);
    chk("readback_rdata", 32'(dm_rdata), 32'hBEEF);

    // Starvation: DM writes back-to-back, IF waiting
    if_at = 0;
    if_req = 1'b1; if_addr = 8'h09;
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 8'h40; dm_wdata = 16'(($urandom));
    for (int c = 1; c <= 6; c++) begin
      tick();
      dm_hist[c] = obs_dm;
      if (obs_if && if_at == 0) if_at = c;
      if (!dm_req && c < 6) begin
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 8'(8'h40 + c); dm_wdata = 16'($urandom);
      end
    end
    dm_req = 1'b0;
    chk("starve_if_cycle", 32'(if_at), 32'd5);
    chk("starve_dm_first4", 32'({dm_hist[1], dm_hist[2], dm_hist[3], dm_hist[4]}), 32'hF);
    chk("starve_dm_c5", 32'(dm_hist[5]), 32'd0);
    chk("starve_dm_c6", 32'(dm_hist[6]), 32'd1);

    // Randomised traffic
    repeat (1500) begin
      if (!if_req && $urandom_range(0, 99) < 60) begin
        if_req = 1'b1; if_addr = 8'($urandom_range(0, 15));
      end
      if (!dm_req && $urandom_range(0, 99) < 70) begin
        dm_req = 1'b1; dm_we = 1'($urandom_range(0, 1));
        dm_addr = 8'($urandom_range(0, 15)); dm_wdata = 16'($urandom);
      end
      tick();
    end
    guard = 0;
    while ((if_req || dm_req || sb_q.size() != 0) && guard < 50) begin
      tick();
      guard++;
    end
    chk("drain_reqs", 32'({if_req, dm_req}), 32'd0);
    tick();
    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);

    // Reset during an in-flight read, MEM_LAT=3
    @(posedge CLOCK_50);
    #1;
    r3_rst = 1'b0;
    r3_dm_req = 1'b1; r3_dm_we = 1'b0; r3_dm_addr = 8'h44;
    @(negedge CLOCK_50);
    chk("r3_gnt", 32'(r3_dm_gnt), 32'd1);
    @(posedge CLOCK_50);
    #1;
    r3_dm_req = 1'b0;
    chk("r3_busy_inflight", 32'(r3_busy), 32'd1);
    r3_rst = 1'b1;
    #1;
    chk("r3_busy_reset", 32'(r3_busy), 32'd0);
    repeat (2) begin
      @(negedge CLOCK_50);
      chk("r3_rvalid_in_reset", 32'({r3_if_rvalid, r3_dm_rvalid}), 32'd0);
    end
    @(posedge CLOCK_50);
    #1;
    r3_rst = 1'b0;
    repeat (6) begin
      @(negedge CLOCK_50);
      chk("r3_no_rvalid", 32'({r3_if_rvalid, r3_dm_rvalid}), 32'd0);
    end
    @(posedge CLOCK_50);
    #1;
    r3_dm_req = 1'b1; r3_dm_addr = 8'h47;
    @(negedge CLOCK_50);
    chk("r3_gnt2", 32'(r3_dm_gnt), 32'd1);
    @(posedge CLOCK_50);
    #1;
    r3_dm_req = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge CLOCK_50);
      chk("r3_rvalid_lat3", 32'(r3_dm_rvalid), 32'(k == 3));
      if (k == 3) chk("r3_rdata", 32'(r3_dm_rdata), 32'(init_word(8'h47)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
